// File: rtl/sadd_feeder.sv
// ---------------------------------------------------------------------------
// sadd_feeder
//   Accepts a parallel operand pair (a, b) and presents it one bit per cycle,
//   LSB first, on x / y. The intended consumer is a bit-serial adder.
//
//   Optional feature macro: SADD_FEED_SKID_EN
//     undefined : one pair in flight; in_ready only in IDLE, so consecutive
//                 words are separated by at least one idle cycle.
//     defined   : adds a one-entry skid buffer, so a pair can be accepted while
//                 a word is shifting and words can stream with no idle gap.
//
//   Handshake: a pair transfers on a rising edge where in_valid & in_ready
//   are both high. in_ready does not depend on in_valid, and in_valid
//   offered while in_ready is low is ignored.
//
// Ports
//   clk          in   clock, rising edge
//   rst_b        in   synchronous active-low reset
//   in_valid     in   a/b carry a valid pair
//   in_ready     out  pair can be accepted this cycle
//   a, b         in   WIDTH-bit operands
//   x, y         out  registered serial bits of A and B, LSB first
//   first        out  bit 0 of a word is on x/y
//   last         out  bit WIDTH-1 of a word is on x/y
//   busy         out  a word bit is on x/y
//   dbg_state_o  out  FSM state (0 = IDLE, 1 = SHIFT)
// ---------------------------------------------------------------------------
module sadd_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             y,
  output logic             first,
  output logic             last,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             accept;
  logic             at_last;

`ifdef SADD_FEED_SKID_EN
  logic             skid_full_q, skid_full_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d;
  logic [WIDTH-1:0] skid_b_q, skid_b_d;

  assign in_ready = ~skid_full_q & rst_b;
`else
  assign in_ready = (state_q == IDLE) & rst_b;
`endif

  assign accept  = in_valid & in_ready;
  assign at_last = (state_q == SHIFT) && (cnt_q == LAST_IDX);

  // The shift registers shift in zeros, so after WIDTH shifts they are empty
  // and x/y read 0 in IDLE without any output gating.
  assign x           = sa_q[0];
  assign y           = sb_q[0];
  assign busy        = (state_q == SHIFT);
  assign first       = busy && (cnt_q == '0);
  assign last        = at_last;
  assign dbg_state_o = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
`ifdef SADD_FEED_SKID_EN
    skid_full_d = skid_full_q;
    skid_a_d    = skid_a_q;
    skid_b_d    = skid_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sa_d    = a;
          sb_d    = b;
        end
      end
      SHIFT: begin
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SADD_FEED_SKID_EN
          // A buffered pair takes priority; in_ready is low while the skid
          // is full, so accept cannot also be high here.
          if (skid_full_q) begin
            sa_d        = skid_a_q;
            sb_d        = skid_b_q;
            skid_full_d = 1'b0;
            state_d     = SHIFT;
          end else if (accept) begin
            sa_d    = a;
            sb_d    = b;
            state_d = SHIFT;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef SADD_FEED_SKID_EN
          if (accept) begin
            skid_a_d    = a;
            skid_b_d    = b;
            skid_full_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
`ifdef SADD_FEED_SKID_EN
      skid_full_q <= 1'b0;
      skid_a_q    <= '0;
      skid_b_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`ifdef SADD_FEED_SKID_EN
      skid_full_q <= skid_full_d;
      skid_a_q    <= skid_a_d;
      skid_b_q    <= skid_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_sadd_feeder.sv
// ---------------------------------------------------------------------------
// tb_sadd_feeder
//   Bench for sadd_feeder (WIDTH = 8), built with or without
//   SADD_FEED_SKID_EN. The reference model is a queue of expected output
//   cycles: each accepted pair appends WIDTH entries {busy,first,last,x,y},
//   and every clock edge moves the head of the queue onto the outputs.
// ---------------------------------------------------------------------------
module tb_sadd_feeder;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, x, y, first, last, busy, dbg_state;

  always #5 clk = ~clk;

  sadd_feeder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .x          (x),
    .y          (y),
    .first      (first),
    .last       (last),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output cycles, each {busy, first, last, x, y}.
  logic [4:0] exp_q[$];
  logic [4:0] cur = '0;
  bit         rst_seen = 1'b0;

  // Model in_ready: without the skid, only when nothing is on the outputs or
  // queued; with the skid, while fewer than a full word is queued behind
  // the bit now on the outputs (i.e. the one-word buffer is free).
  function automatic bit model_ready();
`ifdef SADD_FEED_SKID_EN
    return rst_b && (exp_q.size() < W);
`else
    return rst_b && !cur[4] && (exp_q.size() == 0);
`endif
  endfunction

  always begin
    @(posedge clk);
    if (!rst_b) begin
      exp_q.delete();
      cur      = '0;
      rst_seen = 1'b1;
    end else begin
      if (in_valid && model_ready()) begin
        for (int i = 0; i < W; i++)
          exp_q.push_back({1'b1, (i == 0), (i == W - 1), a[i], b[i]});
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '0;
    end
    #1;
    if (rst_seen)
      check("cycle{rdy,busy,first,last,x,y}", {in_ready, busy, first, last, x, y},
            {model_ready(), cur});
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT idle; sends one pair, scrambles a/b
  // every cycle afterwards, and records what appears on the outputs.
  task automatic send_word(input logic [W-1:0] pa, input logic [W-1:0] pb,
                           output logic [W-1:0] xs, output logic [W-1:0] ys,
                           output int first_at, output int last_at, output int busy_n);
    in_valid = 1'b1;
    a = pa;
    b = pb;
    @(negedge clk);
    in_valid = 1'b0;
    xs = '0;
    ys = '0;
    first_at = -1;
    last_at  = -1;
    busy_n   = 0;
    for (int i = 0; i < W + 2; i++) begin
      if (i < W) begin
        xs[i] = x;
        ys[i] = y;
      end
      if (first && first_at < 0) first_at = i;
      if (last && last_at < 0) last_at = i;
      if (busy) busy_n++;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] xs, ys;
  int           f_at, l_at, b_n;
  logic [19:0]  busy_tr, rdy_tr, x_tr, y_tr, first_tr, last_tr;

  initial begin
    rst_b    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset_outputs", {x, y, first, last, busy}, 5'b0);
    check("reset_ready", in_ready, 1'b1);
    check("model_reset", {model_ready(), cur}, 6'b100000);

    // Single word A5/3C
    send_word(8'hA5, 8'h3C, xs, ys, f_at, l_at, b_n);
    check("a5_x_bits", xs, 8'hA5);
    check("a5_y_bits", ys, 8'h3C);
    check("a5_first_cycle", f_at, 0);
    check("a5_last_cycle", l_at, 7);
    check("a5_busy_cycles", b_n, 8);

`ifndef SADD_FEED_SKID_EN
    // in_valid held high across two words: one idle cycle in between.
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    @(negedge clk);
    a = 8'h00;
    b = 8'h80;
    for (int i = 0; i < 20; i++) begin
      busy_tr[i] = busy;
      rdy_tr[i]  = in_ready;
      x_tr[i]    = x;
      y_tr[i]    = y;
      if (i == 9) in_valid = 1'b0;
      @(negedge clk);
    end
    check("held_busy_trace", busy_tr, 20'h1FEFF);
    check("held_ready_trace", rdy_tr, 20'hE0100);
    check("held_x_trace", x_tr, 20'h000FF);
    check("held_y_trace", y_tr, 20'h10001);
`else
    // Second pair offered during the first word goes to the skid.
    in_valid = 1'b1;
    a = 8'h5A;
    b = 8'hC3;
    @(negedge clk);
    a = 8'h0F;
    b = 8'hF0;
    for (int i = 0; i < 20; i++) begin
      busy_tr[i]  = busy;
      rdy_tr[i]   = in_ready;
      x_tr[i]     = x;
      y_tr[i]     = y;
      first_tr[i] = first;
      last_tr[i]  = last;
      if (i == 1) in_valid = 1'b0;
      @(negedge clk);
    end
    check("skid_busy_trace", busy_tr, 20'h0FFFF);
    check("skid_ready_trace", rdy_tr, 20'hFFF01);
    check("skid_first_trace", first_tr, 20'h00101);
    check("skid_last_trace", last_tr, 20'h08080);
    check("skid_x_trace", x_tr, 20'h00F5A);
    check("skid_y_trace", y_tr, 20'h0F0C3);
`endif

    // Reset while bit 3 of A5/3C is on the outputs.
    in_valid = 1'b1;
    a = 8'hA5;
    b = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bit3_xy", {busy, x, y}, 3'b101);
    rst_b = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {x, y, first, last, busy}, 5'b0);
    check("midreset_ready", in_ready, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);
    check("postreset_ready", {in_ready, busy}, 2'b10);
    send_word(8'h01, 8'h01, xs, ys, f_at, l_at, b_n);
    check("postreset_x_bits", xs, 8'h01);
    check("postreset_y_bits", ys, 8'h01);
    check("postreset_first", f_at, 0);
    check("postreset_busy", b_n, 8);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a        = W'($urandom);
      b        = W'($urandom);
      rst_b    = ($urandom_range(0, 63) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_b    = 1'b1;
    repeat (2 * W + 4) @(negedge clk);
    check("drained_idle", {busy, in_ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
